// File: rtl/uart_pin_bridge.sv
// Full-duplex UART bridging chip pads (rx/tx/cts/rts) to a valid/ready
// character interface, with TX/RX FIFOs, optional parity and sticky errors.
module uart_pin_bridge #(
  parameter int unsigned DataBits    = 8,
  parameter int unsigned FifoDepth   = 8,
  parameter int unsigned DefaultRate = 5207
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic [1:0]                   rate_sel,
  input  logic                         parity_en,
  input  logic                         parity_odd,
  input  logic                         clear,
  input  logic [DataBits-1:0]          tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [DataBits-1:0]          rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FifoDepth):0]   tx_count,
  output logic [$clog2(FifoDepth):0]   rx_count,
  input  logic                         rx,
  output logic                         tx,
  input  logic                         cts,
  output logic                         rts,
  output logic                         err,
  output logic [2:0]                   err_code
);

  localparam int unsigned PW = $clog2(FifoDepth);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full     = CW'(FifoDepth);
  localparam logic [CW-1:0] RtsLevel = CW'(FifoDepth - 1);
  localparam logic [15:0]   BaseRate = 16'(DefaultRate);
  localparam logic [3:0]    LastBit  = 4'(DataBits - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rxState_t;

  txState_t txState, txNext;
  rxState_t rxState, rxNext;

  logic [1:0]  cfgRate;
  logic        cfgParEn, cfgParOdd;
  logic [15:0] rateShift, bitLen, halfLen;

  logic [DataBits-1:0] txMem [FifoDepth];
  logic [PW-1:0]       txWr, txRd;
  logic [CW-1:0]       txCount;
  logic                txPush, txLoad, txTick, txBit, txReg, txParBit;
  logic [15:0]         txBaud;
  logic [3:0]          txBits;
  logic [DataBits-1:0] txShift;

  logic [DataBits-1:0] rxMem [FifoDepth];
  logic [PW-1:0]       rxWr, rxRd;
  logic [CW-1:0]       rxCount;
  logic                rxMeta, rxSync, rxPrev, rxFall, rxTick;
  logic                rxPush, rxGood, rxFrameErr, rxParBad, rxParErr;
  logic                rxFifoPush, rxFifoPop, rxOverrun;
  logic [15:0]         rxBaud;
  logic [3:0]          rxBits;
  logic [DataBits-1:0] rxShift;

  // Latch line configuration only while the link is completely quiet
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cfgRate   <= '0;
      cfgParEn  <= 1'b0;
      cfgParOdd <= 1'b0;
    end else if (txState == TX_IDLE && rxState == RX_IDLE && txCount == '0 && rxCount == '0) begin
      cfgRate   <= rate_sel;
      cfgParEn  <= parity_en;
      cfgParOdd <= parity_odd;
    end
  end

  // Clocks per bit from the latched rate, floored at 4
  always_comb begin
    rateShift = BaseRate >> cfgRate;
    bitLen    = (rateShift < 16'd4) ? 16'd4 : rateShift;
    halfLen   = bitLen >> 1;
  end

  // ---------------- TX FIFO ----------------
  assign txPush   = tx_valid && tx_ready && !clear;
  assign tx_ready = (txCount != Full);
  assign tx_count = txCount;

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWr] <= tx_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      txWr <= '0; txRd <= '0; txCount <= '0;
    end else if (clear) begin
      txWr <= '0; txRd <= '0; txCount <= '0;
    end else begin
      if (txPush) txWr <= txWr + 1'b1;
      if (txLoad) txRd <= txRd + 1'b1;
      case ({txPush, txLoad})
        2'b10:   txCount <= txCount + 1'b1;
        2'b01:   txCount <= txCount - 1'b1;
        default: txCount <= txCount;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  assign txTick = (txBaud == bitLen - 16'd1);

  // TX state register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) txState <= TX_IDLE;
    else         txState <= txNext;
  end

  // TX next state; a new frame may start straight out of STOP for gapless streaming
  always_comb begin
    txNext = txState;
    txLoad = 1'b0;
    if (clear) begin
      txNext = TX_IDLE;
    end else begin
      case (txState)
        TX_IDLE:   if (txCount != '0 && cts) begin txNext = TX_START; txLoad = 1'b1; end
        TX_START:  if (txTick) txNext = TX_DATA;
        TX_DATA:   if (txTick && txBits == LastBit) txNext = cfgParEn ? TX_PARITY : TX_STOP;
        TX_PARITY: if (txTick) txNext = TX_STOP;
        TX_STOP: begin
          if (txTick) begin
            if (txCount != '0 && cts) begin txNext = TX_START; txLoad = 1'b1; end
            else txNext = TX_IDLE;
          end
        end
        default:   txNext = TX_IDLE;
      endcase
    end
  end

  // TX line level implied by the current state
  always_comb begin
    txBit = 1'b1;
    case (txState)
      TX_START:  txBit = 1'b0;
      TX_DATA:   txBit = txShift[0];
      TX_PARITY: txBit = txParBit;
      default:   txBit = 1'b1;
    endcase
  end

  // TX baud/bit counters and character shifter
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      txBaud <= '0; txBits <= '0; txShift <= '0; txParBit <= 1'b0;
    end else if (clear) begin
      txBaud <= '0; txBits <= '0;
    end else if (txLoad) begin
      txShift  <= txMem[txRd];
      txParBit <= (^txMem[txRd]) ^ cfgParOdd;
      txBaud   <= '0;
      txBits   <= '0;
    end else if (txState != TX_IDLE) begin
      if (txTick) begin
        txBaud <= '0;
        if (txState == TX_DATA) begin
          txShift <= txShift >> 1;
          txBits  <= txBits + 4'd1;
        end
      end else begin
        txBaud <= txBaud + 16'd1;
      end
    end
  end

  // Registered pad driver: the line lags the FSM by one clock, giving the
  // two-cycle push-to-start latency while every bit still lasts R clocks
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)    txReg <= 1'b1;
    else if (clear) txReg <= 1'b1;
    else            txReg <= txBit;
  end
  assign tx = txReg;

  // ---------------- RX path ----------------
  // Two-flop synchroniser plus edge-history flop, idle high
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rxMeta <= 1'b1; rxSync <= 1'b1; rxPrev <= 1'b1;
    end else begin
      rxMeta <= rx; rxSync <= rxMeta; rxPrev <= rxSync;
    end
  end
  assign rxFall = rxPrev && !rxSync;
  assign rxTick = (rxState == RX_START) ? (rxBaud == halfLen - 16'd1) : (rxBaud == bitLen - 16'd1);

  // RX state register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) rxState <= RX_IDLE;
    else         rxState <= rxNext;
  end

  // RX next state
  always_comb begin
    rxNext = rxState;
    if (clear) begin
      rxNext = RX_IDLE;
    end else begin
      case (rxState)
        RX_IDLE:      if (rxFall) rxNext = RX_START;
        RX_START:     if (rxTick) rxNext = rxSync ? RX_IDLE : RX_DATA;
        RX_DATA:      if (rxTick && rxBits == LastBit) rxNext = cfgParEn ? RX_PARITY : RX_STOP;
        RX_PARITY:    if (rxTick) rxNext = RX_STOP;
        RX_STOP:      if (rxTick) rxNext = rxSync ? RX_IDLE : RX_WAIT_HIGH;
        RX_WAIT_HIGH: if (rxSync) rxNext = RX_IDLE;
        default:      rxNext = RX_IDLE;
      endcase
    end
  end

  // RX sample outcomes: good character, framing and parity errors
  always_comb begin
    rxGood     = 1'b0;
    rxFrameErr = 1'b0;
    rxParBad   = 1'b0;
    if (!clear && rxTick) begin
      case (rxState)
        RX_PARITY: rxParBad   = (rxSync != ((^rxShift) ^ cfgParOdd));
        RX_STOP: begin
          rxFrameErr = !rxSync;
          rxGood     = rxSync && !rxParErr;
        end
        default: ;
      endcase
    end
  end

  // RX baud/bit counters, deserialiser and deferred push strobe
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rxBaud <= '0; rxBits <= '0; rxShift <= '0; rxParErr <= 1'b0; rxPush <= 1'b0;
    end else if (clear) begin
      rxBaud <= '0; rxBits <= '0; rxParErr <= 1'b0; rxPush <= 1'b0;
    end else begin
      rxPush <= rxGood;
      if (rxState == RX_IDLE || rxState == RX_WAIT_HIGH) begin
        rxBaud <= '0; rxBits <= '0; rxParErr <= 1'b0;
      end else if (rxTick) begin
        rxBaud <= '0;
        if (rxState == RX_DATA) begin
          rxShift <= {rxSync, rxShift[DataBits-1:1]};
          rxBits  <= rxBits + 4'd1;
        end
        if (rxParBad) rxParErr <= 1'b1;
      end else begin
        rxBaud <= rxBaud + 16'd1;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  assign rxFifoPush = rxPush && !clear && (rxCount != Full);
  assign rxOverrun  = rxPush && !clear && (rxCount == Full);
  assign rxFifoPop  = rx_ready && rx_valid && !clear;
  assign rx_valid   = (rxCount != '0);
  assign rx_data    = rx_valid ? rxMem[rxRd] : '0;
  assign rx_count   = rxCount;
  assign rts        = (rxCount >= RtsLevel);

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rxFifoPush) rxMem[rxWr] <= rxShift;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rxWr <= '0; rxRd <= '0; rxCount <= '0;
    end else if (clear) begin
      rxWr <= '0; rxRd <= '0; rxCount <= '0;
    end else begin
      if (rxFifoPush) rxWr <= rxWr + 1'b1;
      if (rxFifoPop)  rxRd <= rxRd + 1'b1;
      case ({rxFifoPush, rxFifoPop})
        2'b10:   rxCount <= rxCount + 1'b1;
        2'b01:   rxCount <= rxCount - 1'b1;
        default: rxCount <= rxCount;
      endcase
    end
  end

  // Sticky {overrun, parity, framing} flags
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)    err_code <= '0;
    else if (clear) err_code <= '0;
    else            err_code <= err_code | {rxOverrun, rxParBad, rxFrameErr};
  end
  assign err = |err_code;

endmodule

// File: tb/tb_uart_pin_bridge.sv
// Scoreboard bench for uart_pin_bridge: stimulus queues expected characters,
// independent monitors check the RX interface and decode the tx pad.
module tb_uart_pin_bridge;
  localparam int DB = 8;
  localparam int FD = 4;
  localparam int DR = 64;

  logic clk = 1'b0;
  logic nReset;
  logic [1:0] rate_sel;
  logic parity_en, parity_odd, clear;
  logic [DB-1:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_ready;
  logic [$clog2(FD):0] tx_count, rx_count;
  logic rx, tx, cts, rts, err;
  logic [2:0] err_code;
  logic loopback, rxDrive;

  assign rx = loopback ? tx : rxDrive;

  always #5 clk = ~clk;

  uart_pin_bridge #(.DataBits(DB), .FifoDepth(FD), .DefaultRate(DR)) dut (
    .clk(clk), .nReset(nReset), .rate_sel(rate_sel), .parity_en(parity_en),
    .parity_odd(parity_odd), .clear(clear), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count), .rx(rx), .tx(tx), .cts(cts), .rts(rts),
    .err(err), .err_code(err_code)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] expQ[$];
  logic [7:0] txQ[$];
  int curR = DR;
  bit curPar = 1'b0;
  bit curOdd = 1'b0;
  bit txAbort = 1'b0;

  function automatic int rateOf(input int sel);
    int r;
    r = DR >> sel;
    return (r < 4) ? 4 : r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX interface monitor: every pop must match the oldest expected character
  initial begin
    forever begin
      @(negedge clk); #1;
      if (nReset && !clear && rx_valid && rx_ready) begin
        if (expQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL rx_unexpected: got %0h expected no character", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(expQ.pop_front()));
        end
      end
    end
  end

  // tx pad decoder: samples mid-bit using the configured bit time
  initial begin : txDecoder
    logic [7:0] d;
    logic st, p, s, e;
    int r;
    forever begin
      @(negedge tx);
      r = curR;
      repeat (r/2) @(posedge clk); #1; st = tx;
      for (int i = 0; i < 8; i++) begin repeat (r) @(posedge clk); #1; d[i] = tx; end
      p = 1'b0;
      if (curPar) begin repeat (r) @(posedge clk); #1; p = tx; end
      repeat (r) @(posedge clk); #1; s = tx;
      if (txQ.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_unexpected: got frame %0h expected none", d);
      end else begin
        e = 1'b0;
        d = d;
        if (txAbort) begin
          void'(txQ.pop_front());
          txAbort = 1'b0;
        end else begin
          logic [7:0] x;
          x = txQ.pop_front();
          check("tx_start", 32'(st), 32'(e));
          check("tx_data", 32'(d), 32'(x));
          if (curPar) check("tx_parity", 32'(p), 32'((^x) ^ curOdd));
          check("tx_stop", 32'(s), 32'(1));
        end
      end
    end
  end

  task automatic pushByte(input logic [7:0] b, input bit expectRx);
    int n;
    n = 0;
    @(negedge clk); tx_valid = 1'b1; tx_data = b;
    while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
    check("push_ready_timeout", 32'(n >= 5000), 32'(0));
    @(posedge clk);
    txQ.push_back(b);
    if (expectRx) expQ.push_back(b);
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic drain(input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || txQ.size() != 0) && n < maxCycles) begin @(posedge clk); n++; end
    check("drain_pending", 32'(expQ.size() + txQ.size()), 32'(0));
    repeat (3*curR) @(posedge clk);
  endtask

  task automatic setCfg(input logic [1:0] sel, input bit pe, input bit po);
    @(negedge clk);
    rate_sel = sel; parity_en = pe; parity_odd = po;
    curR = rateOf(int'(sel)); curPar = pe; curOdd = po;
    repeat (3) @(negedge clk);
  endtask

  // Leaves rx low after a low stop bit so the receiver can be held off
  task automatic sendFrame(input logic [7:0] d, input bit withPar, input logic parBit,
                           input logic stopBit, input int r);
    @(negedge clk); rxDrive = 1'b0;
    repeat (r) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxDrive = d[i]; repeat (r) @(negedge clk); end
    if (withPar) begin rxDrive = parBit; repeat (r) @(negedge clk); end
    rxDrive = stopBit;
    repeat (r) @(negedge clk);
    if (stopBit) rxDrive = 1'b1;
  endtask

  task automatic pulseClear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // Global time bound
  initial begin
    #900000;
    fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int lowCnt, n, m;
    logic [7:0] b, b1, b2;
    nReset = 1'b0; rate_sel = 2'd0; parity_en = 1'b0; parity_odd = 1'b0; clear = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1; cts = 1'b1; loopback = 1'b0; rxDrive = 1'b1;

    // Reset state
    #12;
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_rx_data", 32'(rx_data), 32'(0));
    check("rst_tx_count", 32'(tx_count), 32'(0));
    check("rst_rx_count", 32'(rx_count), 32'(0));
    check("rst_rts", 32'(rts), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_err_code", 32'(err_code), 32'(0));
    @(negedge clk); nReset = 1'b1;
    lowCnt = 0;
    repeat (200) begin @(posedge clk); #1; if (tx !== 1'b1) lowCnt++; end
    check("idle_tx_low_cycles", 32'(lowCnt), 32'(0));

    // Loopback 0xA5 at R=16: start bit at N+2, LSB lasts exactly 16 clocks
    setCfg(2'd2, 1'b0, 1'b0);
    loopback = 1'b1;
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hA5;
    @(posedge clk); txQ.push_back(8'hA5); expQ.push_back(8'hA5);
    #1 check("lat_n", 32'(tx), 32'(1));
    @(negedge clk); tx_valid = 1'b0;
    @(posedge clk); #1 check("lat_n1", 32'(tx), 32'(1));
    @(posedge clk); #1 check("lat_n2", 32'(tx), 32'(0));
    repeat (15) @(posedge clk); #1 check("start_last_clock", 32'(tx), 32'(0));
    @(posedge clk); #1 check("bit0_first_clock", 32'(tx), 32'(1));
    drain(2000);
    check("a5_err", 32'(err), 32'(0));

    // Randomised loopback bursts across rates and parity modes
    for (int it = 0; it < 10; it++) begin
      setCfg(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) pushByte(8'($urandom), 1'b1);
      drain(6000);
      check("rand_err", 32'(err), 32'(0));
    end

    // Odd parity loopback, then a bad-parity injection
    setCfg(2'd2, 1'b1, 1'b1);
    pushByte(8'h3C, 1'b1);
    drain(2000);
    loopback = 1'b0; rxDrive = 1'b1;
    sendFrame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    repeat (32) @(negedge clk);
    check("par_rx_count", 32'(rx_count), 32'(0));
    check("par_err_code", 32'(err_code), 32'(3'b010));
    pulseClear();
    check("par_cleared", 32'(err_code), 32'(0));

    // Framing error, held low in WAIT_HIGH, then a good 0x55
    setCfg(2'd2, 1'b0, 1'b0);
    sendFrame(8'h5A, 1'b0, 1'b0, 1'b0, 16);
    repeat (48) @(negedge clk);
    check("frm_err_code", 32'(err_code), 32'(3'b001));
    check("frm_rx_count", 32'(rx_count), 32'(0));
    rxDrive = 1'b1;
    repeat (32) @(negedge clk);
    expQ.push_back(8'h55);
    sendFrame(8'h55, 1'b0, 1'b0, 1'b1, 16);
    drain(500);
    check("frm_sticky", 32'(err_code), 32'(3'b001));
    pulseClear();

    // Overrun: five characters into a four-entry FIFO with no pops
    @(negedge clk); rx_ready = 1'b0;
    m = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (m < FD) begin expQ.push_back(b); m++; end
      sendFrame(b, 1'b0, 1'b0, 1'b1, 16);
      repeat (16) @(negedge clk);
      check("ovr_rx_count", 32'(rx_count), 32'(m));
      check("ovr_rts", 32'(rts), 32'(m >= FD - 1));
    end
    check("ovr_err_code", 32'(err_code), 32'(3'b100));
    @(negedge clk); rx_ready = 1'b1;
    drain(200);

    // Flow control hold, mid-frame cts drop, then clear mid-frame
    @(negedge clk); cts = 1'b0;
    b1 = 8'($urandom); b2 = 8'($urandom);
    pushByte(b1, 1'b0);
    pushByte(b2, 1'b0);
    check("cts_tx_count", 32'(tx_count), 32'(2));
    lowCnt = 0;
    repeat (100) begin @(posedge clk); #1; if (tx !== 1'b1) lowCnt++; end
    check("cts_hold_low_cycles", 32'(lowCnt), 32'(0));
    @(negedge clk); cts = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    check("cts_first_start", 32'(tx), 32'(0));
    repeat (5) @(negedge clk); cts = 1'b0;
    repeat (10*16 + 20) @(negedge clk);
    check("cts_second_held", 32'(tx_count), 32'(1));
    lowCnt = 0;
    repeat (100) begin @(posedge clk); #1; if (tx !== 1'b1) lowCnt++; end
    check("cts_second_low_cycles", 32'(lowCnt), 32'(0));
    check("cts_first_done", 32'(txQ.size()), 32'(1));
    @(negedge clk); cts = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    check("clr_frame_started", 32'(tx), 32'(0));
    txAbort = 1'b1;
    repeat (40) @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    check("clr_tx", 32'(tx), 32'(1));
    check("clr_tx_count", 32'(tx_count), 32'(0));
    check("clr_err", 32'(err), 32'(0));
    @(negedge clk); clear = 1'b0;
    lowCnt = 0;
    repeat (200) begin @(posedge clk); #1; if (tx !== 1'b1) lowCnt++; end
    check("clr_tx_idle_low_cycles", 32'(lowCnt), 32'(0));
    check("clr_rx_count", 32'(rx_count), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
